dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, data and address width.
REQ-002 SHALL provide parameter FAIR_LIMIT, default 4, consecutive CPU wins tolerated while debug waits.
REQ-003 SHALL have port clock, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports cpu_req, cpu_we, input, 1, MEM-stage access request and store enable.
REQ-006 SHALL have ports cpu_addr, cpu_wdata, input, DATA_W, MEM-stage ALU address and store data.
REQ-007 SHALL have port cpu_stall, output, 1, freeze request to the pipeline.
REQ-008 SHALL have ports cpu_rvalid, output, 1, and cpu_rdata, output, DATA_W, load return.
REQ-009 SHALL have ports dbg_req, dbg_we, input, 1, and dbg_addr, dbg_wdata, input, DATA_W, debug/IO-scanner requester.
REQ-010 SHALL have ports dbg_ack, output, 1, and dbg_rdata, output, DATA_W, debug completion.
REQ-011 SHALL have ports mem_en, mem_we, output, 1, and mem_addr, mem_wdata, output, DATA_W, data-memory issue.
REQ-012 SHALL have port mem_rdata, input, DATA_W, registered-read data, valid the cycle after a read issue.

Function
REQ-013 SHALL use FSM states IDLE, CPU_RD, DBG_RD; at most one memory issue per cycle, issue only in IDLE.
REQ-014 In IDLE, with requests present, SHALL grant CPU unless dbg_req=1 and starve_cnt==FAIR_LIMIT, then grant debug.
REQ-015 SHALL increment starve_cnt when dbg_req=1 and CPU is granted, saturating at FAIR_LIMIT; clear it when debug is granted or dbg_req=0.
REQ-016 On grant SHALL drive mem_en=1, mem_we=granted we, mem_addr/mem_wdata from the granted requester, combinationally, same cycle; otherwise mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-017 Granted read SHALL move IDLE->CPU_RD or IDLE->DBG_RD; granted write SHALL stay in IDLE.
REQ-018 CPU_RD and DBG_RD SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-019 In CPU_RD SHALL assert cpu_rvalid=1 and cpu_rdata=mem_rdata; otherwise cpu_rvalid=0 and cpu_rdata=0.
REQ-020 cpu_stall SHALL equal (cpu_req and not CPU-granted-write in IDLE) and not CPU_RD: CPU store costs 0 stall cycles uncontested, a CPU load costs 1.
REQ-021 dbg_ack SHALL pulse 1 cycle: on a debug write-grant cycle, or in DBG_RD with dbg_rdata=mem_rdata; dbg_rdata=0 otherwise.
REQ-022 Requesters SHALL hold req/we/addr/wdata stable until completion; arbiter samples them only at issue.
REQ-023 A request dropped before grant SHALL be ignored without side effect.
REQ-024 Simultaneous requests in CPU_RD/DBG_RD SHALL wait for IDLE; no issue is lost or duplicated.

Reset
REQ-025 reset=1 SHALL force state IDLE, starve_cnt=0 at the next edge, and all outputs 0 while reset is asserted.
REQ-026 Reset during CPU_RD/DBG_RD SHALL discard the outstanding read: no cpu_rvalid or dbg_ack after reset.

Structure
REQ-027 Package dmem_arb_pkg SHALL hold the state enum, DATA_W and FAIR_LIMIT defaults.
REQ-028 The starvation counter SHALL be a sub-module dmem_arb_fair_cnt (inc, clr, sat output); the rest is one flat module.

Verification
REQ-029 CPU store cpu_addr=0x10, cpu_wdata=0xDEADBEEF, no debug -> same-cycle mem_en=1, mem_we=1, cpu_stall=0.
REQ-030 CPU load at 0x10 with mem_rdata=0xDEADBEEF -> cycle0 mem_en=1, cpu_stall=1; cycle1 cpu_rvalid=1, cpu_rdata=0xDEADBEEF, cpu_stall=0.
REQ-031 cpu_req stores every cycle with dbg_req write held -> CPU granted 4 issues, 5th issue goes to debug with dbg_ack=1 and cpu_stall=1 that cycle, starve_cnt returns to 0.
REQ-032 Debug read at 0x20 and CPU idle -> DBG_RD next cycle, dbg_ack=1, dbg_rdata=mem_rdata, no cpu_rvalid.
REQ-033 reset=1 asserted during CPU_RD -> no cpu_rvalid, state IDLE, all outputs 0 while reset is held.
REQ-034 Both requesting, starve_cnt<4, CPU load -> CPU first; debug issues the cycle after CPU_RD, never during it.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// The CPU MEM stage and the debug/IO scanner share one data memory port.
package dmem_arb_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int FAIR_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_RD = 2'd1,
    DBG_RD = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dmem_arb_fair_cnt.sv
// Saturating count of CPU wins while debug is waiting.
// sat tells the arbiter that debug must win the next issue.
module dmem_arb_fair_cnt
  import dmem_arb_pkg::*;
#(
  parameter int LIMIT = FAIR_LIMIT_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int CW = $clog2(LIMIT + 2);

  logic [CW-1:0] cnt_q, cnt_d;

  assign sat = (cnt_q == CW'(LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && !sat)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: CPU by default, debug after
// FAIR_LIMIT consecutive CPU wins; one issue per cycle, 1-cycle reads.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FAIR_LIMIT = FAIR_LIMIT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [DATA_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e state_q, state_d;

  logic idle, in_crd, in_drd;
  logic sat, cpu_win, dbg_win;

  // Gating with reset keeps every output at 0 while reset is held.
  assign idle   = !reset && (state_q == IDLE);
  assign in_crd = !reset && (state_q == CPU_RD);
  assign in_drd = !reset && (state_q == DBG_RD);

  assign dbg_win = idle && dbg_req && (sat || !cpu_req);
  assign cpu_win = idle && cpu_req && !dbg_win;

  dmem_arb_fair_cnt #(
    .LIMIT(FAIR_LIMIT)
  ) u_fair (
    .clock(clock),
    .reset(reset),
    .inc  (cpu_win && dbg_req),
    .clr  (dbg_win || !dbg_req),
    .sat  (sat)
  );

  always_ff @(posedge clock) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_win && !cpu_we)
          state_d = CPU_RD;
        else if (dbg_win && !dbg_we)
          state_d = DBG_RD;
      end
      CPU_RD:  state_d = IDLE;
      DBG_RD:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      cpu_win: begin
        mem_en    = 1'b1;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      dbg_win: begin
        mem_en    = 1'b1;
        mem_we    = dbg_we;
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
      end
      default: ;
    endcase
    cpu_rvalid = in_crd;
    cpu_rdata  = in_crd ? mem_rdata : '0;
    dbg_ack    = (dbg_win && dbg_we) || in_drd;
    dbg_rdata  = in_drd ? mem_rdata : '0;
    // A granted store retires at once; a load waits for CPU_RD.
    cpu_stall  = !reset && cpu_req && !in_crd &&
                 !(cpu_win && cpu_we);
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed cases plus
// randomized requesters against a transaction-level memory model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int W   = 32;
  localparam int LIM = FAIR_LIMIT_DEF;

  logic         clock = 1'b0;
  logic         reset;
  logic         cpu_req, cpu_we, cpu_stall, cpu_rvalid;
  logic [W-1:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic         dbg_req, dbg_we, dbg_ack;
  logic [W-1:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic         mem_en, mem_we;
  logic [W-1:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clock = ~clock;

  dmem_arbiter #(.DATA_W(W), .FAIR_LIMIT(LIM)) dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_stall (cpu_stall),
    .cpu_rvalid(cpu_rvalid),
    .cpu_rdata (cpu_rdata),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_ack   (dbg_ack),
    .dbg_rdata (dbg_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: who owns the read returning this cycle (0 none, 1 cpu,
  // 2 dbg), CPU wins while debug waited, and the memory contents.
  int           pend   = 0;
  int           starve = 0;
  logic [W-1:0] mem [64];
  logic [W-1:0] last_rd = '0;
  int           g;

  logic         o_en, o_we, o_stall, o_rv, o_ack;
  logic [W-1:0] o_addr, o_rdata, o_drdata;

  task automatic chk(input string tag, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic rst,
                      input logic cr, input logic cw,
                      input logic [W-1:0] ca, input logic [W-1:0] cd,
                      input logic dr, input logic dw,
                      input logic [W-1:0] da, input logic [W-1:0] dd,
                      output int gr);
    logic         ew, es, erv, eack;
    logic [W-1:0] ea, ed, erd, edrd;
    @(negedge clock);
    reset = rst;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
    #1;
    gr = 0;
    if (!rst && pend == 0) begin
      if (dr && (starve >= LIM || !cr)) gr = 2;
      else if (cr) gr = 1;
    end
    ew = 1'b0; ea = '0; ed = '0;
    if (gr == 1) begin ew = cw; ea = ca; ed = cd; end
    if (gr == 2) begin ew = dw; ea = da; ed = dd; end
    es   = !rst && cr && pend != 1 && !(gr == 1 && cw);
    erv  = !rst && pend == 1;
    erd  = erv ? last_rd : '0;
    eack = !rst && ((gr == 2 && dw) || pend == 2);
    edrd = (!rst && pend == 2) ? last_rd : '0;
    o_en = mem_en; o_we = mem_we; o_addr = mem_addr;
    o_stall = cpu_stall; o_rv = cpu_rvalid; o_rdata = cpu_rdata;
    o_ack = dbg_ack; o_drdata = dbg_rdata;
    chk({tag, ".en"},    W'(mem_en),     W'(gr != 0));
    chk({tag, ".we"},    W'(mem_we),     W'(ew));
    chk({tag, ".addr"},  mem_addr,       ea);
    chk({tag, ".wdata"}, mem_wdata,      ed);
    chk({tag, ".stall"}, W'(cpu_stall),  W'(es));
    chk({tag, ".rv"},    W'(cpu_rvalid), W'(erv));
    chk({tag, ".rdata"}, cpu_rdata,      erd);
    chk({tag, ".ack"},   W'(dbg_ack),    W'(eack));
    chk({tag, ".drdat"}, dbg_rdata,      edrd);
    @(posedge clock);
    mem_rdata = $urandom;
    if (rst) begin
      pend = 0;
      starve = 0;
    end else begin
      if (gr == 1 && dr) starve = (starve < LIM) ? starve + 1 : LIM;
      if (gr == 2 || !dr) starve = 0;
      pend = 0;
      if (gr != 0) begin
        if (ew) mem[ea[7:2]] = ed;
        else begin
          pend = gr;
          last_rd = mem[ea[7:2]];
          mem_rdata = last_rd;
        end
      end
    end
  endtask

  bit           c_act, c_iss, c_we, d_act, d_iss, d_we;
  logic [W-1:0] c_a, c_d, d_a, d_d;
  int           pb;

  initial begin
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    mem_rdata = '0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;

    // Reset with live requests: outputs must stay 0
    step("rst0", 1, 1, 0, 32'h10, 32'h1, 1, 1, 32'h20, 32'h2, g);
    step("rst1", 1, 1, 1, 32'h10, 32'h1, 1, 0, 32'h20, 32'h2, g);
    chk("rst.en", W'(o_en), 0);

    step("st", 0, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, g);
    chk("st.en", W'(o_en), 1);
    chk("st.we", W'(o_we), 1);
    chk("st.stall", W'(o_stall), 0);

    step("ld0", 0, 1, 0, 32'h10, 0, 0, 0, 0, 0, g);
    chk("ld0.stall", W'(o_stall), 1);
    step("ld1", 0, 1, 0, 32'h10, 0, 0, 0, 0, 0, g);
    chk("ld1.rv", W'(o_rv), 1);
    chk("ld1.rdata", o_rdata, 32'hDEADBEEF);
    chk("ld1.stall", W'(o_stall), 0);

    step("dr0", 0, 0, 0, 0, 0, 1, 0, 32'h20, 0, g);
    chk("dr0.en", W'(o_en), 1);
    step("dr1", 0, 0, 0, 0, 0, 1, 0, 32'h20, 0, g);
    chk("dr1.ack", W'(o_ack), 1);
    chk("dr1.rdata", o_drdata, mem[8]);
    chk("dr1.rv", W'(o_rv), 0);

    // Fairness: four CPU stores win, the fifth issue goes to debug
    step("fr", 1, 0, 0, 0, 0, 0, 0, 0, 0, g);
    for (int k = 0; k <= LIM; k++) begin
      step("fair", 0, 1, 1, 32'h40 + W'(k * 4), W'(k),
           1, 1, 32'h30, 32'hCAFE0001, g);
      if (k < LIM) begin
        chk("fair.cpu_addr", o_addr, 32'h40 + W'(k * 4));
        chk("fair.noack", W'(o_ack), 0);
      end else begin
        chk("fair.dbg_addr", o_addr, 32'h30);
        chk("fair.ack", W'(o_ack), 1);
        chk("fair.stall", W'(o_stall), 1);
      end
    end
    step("fair2", 0, 1, 1, 32'h50, 32'h5, 1, 1, 32'h34, 32'h6, g);
    chk("fair2.cpu", o_addr, 32'h50);

    // Reset during CPU_RD discards the load
    step("rr0", 0, 1, 0, 32'h10, 0, 0, 0, 0, 0, g);
    step("rr1", 1, 1, 0, 32'h10, 0, 0, 0, 0, 0, g);
    chk("rr1.rv", W'(o_rv), 0);
    chk("rr1.stall", W'(o_stall), 0);
    step("rr2", 0, 0, 0, 0, 0, 0, 0, 0, 0, g);
    chk("rr2.rv", W'(o_rv), 0);

    // Contention: CPU load first, debug only after CPU_RD
    step("cb0", 0, 1, 0, 32'h10, 0, 1, 0, 32'h20, 0, g);
    chk("cb0.addr", o_addr, 32'h10);
    step("cb1", 0, 1, 0, 32'h10, 0, 1, 0, 32'h20, 0, g);
    chk("cb1.en", W'(o_en), 0);
    chk("cb1.rv", W'(o_rv), 1);
    step("cb2", 0, 0, 0, 0, 0, 1, 0, 32'h20, 0, g);
    chk("cb2.addr", o_addr, 32'h20);
    step("cb3", 0, 0, 0, 0, 0, 1, 0, 32'h20, 0, g);
    chk("cb3.ack", W'(o_ack), 1);

    // Randomized requesters that hold until completion or drop early
    c_act = 0; c_iss = 0; d_act = 0; d_iss = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!c_act && $urandom_range(0, 2) == 0) begin
        c_act = 1; c_iss = 0; c_we = 1'($urandom_range(0, 1));
        c_a = W'($urandom_range(0, 63)) << 2; c_d = $urandom;
      end else if (c_act && !c_iss && $urandom_range(0, 7) == 0) begin
        c_act = 0;
      end
      if (!d_act && $urandom_range(0, 3) == 0) begin
        d_act = 1; d_iss = 0; d_we = 1'($urandom_range(0, 1));
        d_a = W'($urandom_range(0, 63)) << 2; d_d = $urandom;
      end else if (d_act && !d_iss && $urandom_range(0, 9) == 0) begin
        d_act = 0;
      end
      pb = pend;
      step("rnd", 0, c_act, c_we, c_a, c_d, d_act, d_we, d_a, d_d, g);
      if (pb == 1) c_act = 0;
      if (pb == 2) d_act = 0;
      if (g == 1) begin
        if (c_we) c_act = 0;
        else c_iss = 1;
      end
      if (g == 2) begin
        if (d_we) d_act = 0;
        else d_iss = 1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
